// File: rtl/g15_timing_pkg.sv
// rtl/g15_timing_pkg.sv - drum timing track constants, counter types and writer states
package g15_timing_pkg;

    localparam int N_BITS    = 29;
    localparam int N_WORDS   = 108;
    localparam int LAST_BIT  = N_BITS - 1;
    localparam int LAST_WORD = N_WORDS - 1;

    localparam logic [N_BITS-1:0] TM_PAT = 29'b0_1101000_1_1100000_01_10000_00000_0;

    typedef logic [$clog2(N_BITS)-1:0]  bit_t;
    typedef logic [$clog2(N_WORDS)-1:0] word_t;

    typedef enum logic [1:0] {
        TW_IDLE,
        TW_ARM,
        TW_WRITE,
        TW_DONE
    } tw_state_t;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD counter with enable and wrap strobe
module mod_counter #(
    parameter int MOD = 29,
    parameter int W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // wrap is qualified by inc so a cascaded counter only advances on a real rollover
    assign wrap = inc && (q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (wrap) begin
            q <= '0;
        end else if (inc) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/timing_track_writer.sv
// rtl/timing_track_writer.sv - bit/word timing generator with one-revolution track re-record
module timing_track_writer
    import g15_timing_pkg::*;
(
    input  logic       CLOCK,
    input  logic       rst_n,
    input  logic       start,
    output logic       TM,
    output logic       CN,
    output logic       CE,
    output logic       CF,
    output logic       wr_en,
    output logic       busy,
    output logic       done,
    output logic [4:0] bit_cnt,
    output logic [6:0] word_cnt
);

    bit_t      bit_q;
    word_t     word_q;
    logic      bit_wrap;
    logic      last_bit;
    logic      index;
    bit_t      tm_idx;
    tw_state_t state;

    mod_counter #(.MOD(N_BITS)) u_bit_counter (
        .clk   (CLOCK),
        .rst_n (rst_n),
        .inc   (1'b1),
        .q     (bit_q),
        .wrap  (bit_wrap)
    );

    // word counter's wrap coincides with the final bit of the revolution
    mod_counter #(.MOD(N_WORDS)) u_word_counter (
        .clk   (CLOCK),
        .rst_n (rst_n),
        .inc   (bit_wrap),
        .q     (word_q),
        .wrap  (last_bit)
    );

    assign index  = (bit_q == '0) && (word_q == '0);
    assign tm_idx = bit_t'(LAST_BIT) - bit_q;

    assign TM = TM_PAT[tm_idx];
    assign CN = (word_q != word_t'(LAST_WORD));
    assign CE = ~word_q[0];
    assign CF = word_q[1];

    assign bit_cnt  = bit_q;
    assign word_cnt = word_q;

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state <= TW_IDLE;
        end else begin
            case (state)
                TW_IDLE:  if (start)    state <= TW_ARM;
                TW_ARM:   if (index)    state <= TW_WRITE;
                TW_WRITE: if (last_bit) state <= TW_DONE;
                TW_DONE:                state <= TW_IDLE;
                default:                state <= TW_IDLE;
            endcase
        end
    end

    // the ARM term lets the write open on the index bit itself rather than one bit late
    assign wr_en = (state == TW_WRITE) || ((state == TW_ARM) && index);
    assign busy  = (state == TW_ARM) || (state == TW_WRITE);
    assign done  = (state == TW_DONE);

endmodule
